// File: rtl/paula_audio_mixer_seq.sv
// Sequential Paula-style audio mixer: one multiply-accumulate per clock, routed left/right.
// Define PAULA_MIXER_SAT_EN to clamp out-of-range sums instead of wrapping them.
module paula_audio_mixer_seq #(
    parameter int NCH = 4,
    parameter int OW  = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clk7_en,
    input  logic                  start,
    input  logic [NCH*8-1:0]      sample,
    input  logic [NCH*7-1:0]      vol,
    input  logic [NCH-1:0]        route,
    output logic signed [OW-1:0]  ldatasum,
    output logic signed [OW-1:0]  rdatasum,
    output logic                  valid,
    output logic                  busy,
    output logic                  overrun
);

    localparam int AW   = 14 + $clog2(NCH) + 1;
    localparam int IW   = $clog2(NCH);
    localparam int OMAX = (2 ** (OW - 1)) - 1;
    localparam int OMIN = -(2 ** (OW - 1));

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic signed [AW-1:0]   accL_q, accL_d;
    logic signed [AW-1:0]   accR_q, accR_d;
    logic [NCH*8-1:0]       sample_q, sample_d;
    logic [NCH*7-1:0]       vol_q, vol_d;
    logic [NCH-1:0]         route_q, route_d;
    logic signed [OW-1:0]   lsum_q, lsum_d;
    logic signed [OW-1:0]   rsum_q, rsum_d;
    logic                   valid_q, valid_d;
    logic                   overrun_q, overrun_d;

    logic [7:0]             chSample;
    logic [6:0]             chVol;
    logic [6:0]             effVol;
    logic signed [13:0]     prod;
    logic signed [AW-1:0]   prodExt;
    logic                   startReq;

    // The current channel's product always comes from the snapshot, never the live inputs.
    assign chSample = sample_q[int'(idx_q) * 8 +: 8];
    assign chVol    = vol_q[int'(idx_q) * 7 +: 7];
    assign effVol   = chVol[6] ? 7'd64 : {1'b0, chVol[5:0]};
    assign prod     = $signed({{6{chSample[7]}}, chSample}) * $signed({7'b0, effVol});
    assign prodExt  = {{(AW - 14){prod[13]}}, prod};
    assign startReq = start && clk7_en;

    function automatic logic signed [OW-1:0] toOut(input logic signed [AW-1:0] a);
`ifdef PAULA_MIXER_SAT_EN
        int v;
        v = int'(a);
        if (v > OMAX) begin
            return OW'(OMAX);
        end else if (v < OMIN) begin
            return OW'(OMIN);
        end
        return OW'(a);
`else
        return OW'(a);
`endif
    endfunction

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        accL_d    = accL_q;
        accR_d    = accR_q;
        sample_d  = sample_q;
        vol_d     = vol_q;
        route_d   = route_q;
        lsum_d    = lsum_q;
        rsum_d    = rsum_q;
        valid_d   = 1'b0;
        overrun_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (startReq) begin
                    state_d  = MAC;
                    idx_d    = '0;
                    accL_d   = '0;
                    accR_d   = '0;
                    sample_d = sample;
                    vol_d    = vol;
                    route_d  = route;
                end
            end
            MAC: begin
                overrun_d = startReq;
                if (route_q[idx_q]) begin
                    accL_d = accL_q + prodExt;
                end else begin
                    accR_d = accR_q + prodExt;
                end
                // Sums are registered on the last MAC edge so they are present during OUT.
                if (idx_q == IW'(NCH - 1)) begin
                    state_d = OUT;
                    lsum_d  = toOut(accL_d);
                    rsum_d  = toOut(accR_d);
                    valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            OUT: begin
                overrun_d = startReq;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            accL_q    <= '0;
            accR_q    <= '0;
            sample_q  <= '0;
            vol_q     <= '0;
            route_q   <= '0;
            lsum_q    <= '0;
            rsum_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            accL_q    <= accL_d;
            accR_q    <= accR_d;
            sample_q  <= sample_d;
            vol_q     <= vol_d;
            route_q   <= route_d;
            lsum_q    <= lsum_d;
            rsum_q    <= rsum_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign ldatasum = lsum_q;
    assign rdatasum = rsum_q;
    assign valid    = valid_q;
    assign overrun  = overrun_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_paula_audio_mixer_seq.sv
// Self-checking bench for paula_audio_mixer_seq: directed table, hand sequences and randomized passes.
module tb_paula_audio_mixer_seq;

    localparam int NCH = 4;
    localparam int OW  = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_n;
    logic               clk7_en;
    logic               start;
    logic [31:0]        sample;
    logic [27:0]        vol;
    logic [3:0]         route;
    logic signed [14:0] ldatasum;
    logic signed [14:0] rdatasum;
    logic               valid;
    logic               busy;
    logic               overrun;

    logic               start8;
    logic [63:0]        sample8;
    logic [55:0]        vol8;
    logic [7:0]         route8;
    logic signed [17:0] ldatasum8;
    logic signed [17:0] rdatasum8;
    logic               valid8;
    logic               busy8;
    logic               overrun8;

    int nChecks = 0;
    int nFails  = 0;

    paula_audio_mixer_seq #(.NCH(NCH), .OW(OW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clk7_en  (clk7_en),
        .start    (start),
        .sample   (sample),
        .vol      (vol),
        .route    (route),
        .ldatasum (ldatasum),
        .rdatasum (rdatasum),
        .valid    (valid),
        .busy     (busy),
        .overrun  (overrun)
    );

    paula_audio_mixer_seq #(.NCH(8), .OW(18)) dut8 (
        .clk      (clk),
        .reset_n  (reset_n),
        .clk7_en  (clk7_en),
        .start    (start8),
        .sample   (sample8),
        .vol      (vol8),
        .route    (route8),
        .ldatasum (ldatasum8),
        .rdatasum (rdatasum8),
        .valid    (valid8),
        .busy     (busy8),
        .overrun  (overrun8)
    );

`ifdef PAULA_MIXER_SAT_EN
    localparam int NEG_FULL_L = -16384;
    localparam int POS_FULL_L = 16383;
`else
    localparam int NEG_FULL_L = 0;
    localparam int POS_FULL_L = -256;
`endif

    typedef struct {
        logic [31:0] s;
        logic [27:0] v;
        logic [3:0]  r;
        int          expL;
        int          expR;
    } vec_t;

    vec_t tbl[7];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int got, input int exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Reduce an unbounded sum to the OW-bit output the way the build option dictates.
    function automatic int toOW(input int s, input int ow);
        int w;
`ifdef PAULA_MIXER_SAT_EN
        if (s > (1 <<< (ow - 1)) - 1) return (1 <<< (ow - 1)) - 1;
        if (s < -(1 <<< (ow - 1)))   return -(1 <<< (ow - 1));
        return s;
`else
        w = s & ((1 <<< ow) - 1);
        if (w >= (1 <<< (ow - 1))) w = w - (1 <<< ow);
        return w;
`endif
    endfunction

    function automatic int refSum(input logic [31:0] s, input logic [27:0] v,
                                  input logic [3:0] r, input bit left);
        int acc;
        int smp;
        int eff;
        acc = 0;
        for (int ch = 0; ch < 4; ch++) begin
            smp = $signed(s[8*ch +: 8]);
            eff = v[7*ch + 6] ? 64 : int'(v[7*ch +: 6]);
            if (r[ch] == left) acc += smp * eff;
        end
        return toOW(acc, OW);
    endfunction

    // One full pass; inputs are scrambled right after accept, and an optional drop request is made at cycle dropAt.
    task automatic applyStimulus(input logic [31:0] s, input logic [27:0] v, input logic [3:0] r,
                                 input int expL, input int expR, input int dropAt, input string tag);
        int lat, vcnt, ocnt, olat, gotL, gotR;
        logic busyFirst, busyAfter;
        logic [31:0] rnd;
        lat = 0; vcnt = 0; ocnt = 0; olat = 0; gotL = 0; gotR = 0;
        busyFirst = 1'b0; busyAfter = 1'b1;
        sample  = s;
        vol     = v;
        route   = r;
        clk7_en = 1'b1;
        start   = 1'b1;
        tick();
        rnd    = $urandom();
        sample = rnd;
        rnd    = $urandom();
        vol    = rnd[27:0];
        route  = rnd[31:28];
        for (int n = 1; n <= 12; n++) begin
            if (valid) begin
                vcnt++;
                if (lat == 0) begin
                    lat  = n;
                    gotL = ldatasum;
                    gotR = rdatasum;
                end
            end
            if (overrun) begin
                ocnt++;
                if (olat == 0) olat = n;
            end
            if (n == 1)       busyFirst = busy;
            if (n == NCH + 2) busyAfter = busy;
            start   = (n == dropAt) ? 1'b1 : 1'($urandom_range(0, 1));
            clk7_en = (n == dropAt);
            tick();
        end
        start   = 1'b0;
        clk7_en = 1'b0;
        checkOutput({tag, " latency"}, lat, NCH + 1);
        checkOutput({tag, " valid count"}, vcnt, 1);
        checkOutput({tag, " ldatasum"}, gotL, expL);
        checkOutput({tag, " rdatasum"}, gotR, expR);
        checkOutput({tag, " ldatasum hold"}, int'(ldatasum), expL);
        checkOutput({tag, " rdatasum hold"}, int'(rdatasum), expR);
        checkOutput({tag, " busy in MAC"}, int'(busyFirst), 1);
        checkOutput({tag, " busy after"}, int'(busyAfter), 0);
        checkOutput({tag, " overrun count"}, ocnt, (dropAt != 0) ? 1 : 0);
        if (dropAt != 0) checkOutput({tag, " overrun cycle"}, olat, dropAt + 1);
    endtask

    initial begin
        int vcnt, lat, gotL, gotR;
        logic [31:0] rs;
        logic [31:0] rnd;
        logic [27:0] rv;
        logic [3:0]  rr;

        tbl[0] = '{32'h7F7F7F7F, {4{7'h40}}, 4'b0110, 16256, 16256};
        tbl[1] = '{32'h80808080, {4{7'h7F}}, 4'b1111, NEG_FULL_L, 0};
        tbl[2] = '{32'h7F7F7F7F, {4{7'h00}}, 4'b1010, 0, 0};
        tbl[3] = '{32'h00000001, {21'h0, 7'h3F}, 4'b0001, 63, 0};
        tbl[4] = '{32'h7F7F7F7F, {4{7'h40}}, 4'b1111, POS_FULL_L, 0};
        tbl[5] = '{32'hFF408005, {7'h7F, 7'h3F, 7'h01, 7'h20}, 4'b1010, -192, 4192};
        tbl[6] = '{32'h00000010, {21'h0, 7'h20}, 4'b0000, 0, 512};

        reset_n = 1'b0;
        clk7_en = 1'b1;
        start   = 1'b1;
        sample  = 32'h7F7F7F7F;
        vol     = {4{7'h40}};
        route   = 4'hF;
        start8  = 1'b1;
        sample8 = '0;
        vol8    = '0;
        route8  = '0;
        tick();
        tick();
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset valid", int'(valid), 0);
        checkOutput("reset overrun", int'(overrun), 0);
        checkOutput("reset ldatasum", int'(ldatasum), 0);
        checkOutput("reset rdatasum", int'(rdatasum), 0);
        checkOutput("reset busy8", int'(busy8), 0);
        start8  = 1'b0;
        start   = 1'b1;
        clk7_en = 1'b0;
        reset_n = 1'b1;
        tick();
        tick();
        checkOutput("start without clk7_en", int'(busy), 0);
        start = 1'b0;

        $display("[TB] directed table");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(tbl[i].s, tbl[i].v, tbl[i].r, tbl[i].expL, tbl[i].expR, 0,
                          $sformatf("table%0d", i));
        end

        $display("[TB] dropped start requests");
        applyStimulus(tbl[0].s, tbl[0].v, tbl[0].r, 16256, 16256, 2, "drop in MAC");
        applyStimulus(tbl[5].s, tbl[5].v, tbl[5].r, -192, 4192, 5, "drop in OUT");
        applyStimulus(tbl[3].s, tbl[3].v, tbl[3].r, 63, 0, 1, "drop first MAC");

        $display("[TB] reset mid-pass");
        applyStimulus(tbl[0].s, tbl[0].v, tbl[0].r, 16256, 16256, 0, "pre-reset");
        sample  = tbl[5].s;
        vol     = tbl[5].v;
        route   = tbl[5].r;
        clk7_en = 1'b1;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        clk7_en = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        checkOutput("midreset busy", int'(busy), 0);
        checkOutput("midreset ldatasum", int'(ldatasum), 0);
        checkOutput("midreset rdatasum", int'(rdatasum), 0);
        checkOutput("midreset valid", int'(valid), 0);
        reset_n = 1'b1;
        vcnt = 0;
        for (int n = 0; n < 10; n++) begin
            if (valid) vcnt++;
            tick();
        end
        checkOutput("midreset no valid", vcnt, 0);

        $display("[TB] randomized passes");
        for (int i = 0; i < 24; i++) begin
            rs  = $urandom();
            rnd = $urandom();
            rv  = rnd[27:0];
            rr  = rnd[31:28];
            applyStimulus(rs, rv, rr, refSum(rs, rv, rr, 1'b1), refSum(rs, rv, rr, 1'b0),
                          int'($urandom_range(0, 5)), $sformatf("rand%0d", i));
        end

        $display("[TB] eight-channel instance");
        sample8 = {8{8'h7F}};
        vol8    = {8{7'h40}};
        route8  = 8'hFF;
        clk7_en = 1'b1;
        start8  = 1'b1;
        tick();
        start8  = 1'b0;
        clk7_en = 1'b0;
        sample8 = '0;
        lat = 0; gotL = 0; gotR = 0;
        for (int n = 1; n <= 14; n++) begin
            if (valid8 && lat == 0) begin
                lat  = n;
                gotL = ldatasum8;
                gotR = rdatasum8;
            end
            tick();
        end
        checkOutput("nch8 latency", lat, 9);
        checkOutput("nch8 ldatasum", gotL, 65024);
        checkOutput("nch8 rdatasum", gotR, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/paula_audio_mixer_seq.md
PAULA_AUDIO_MIXER_SEQ -- requirements
Module: paula_audio_mixer_seq

Interface
REQ-001 Parameter NCH, default 4: number of audio channels, legal range 2..8.
REQ-002 Parameter OW, default 15: width of each output sum, legal range 14..18.
REQ-003 Port clk, input, 1: bus clock (28 MHz); the only clock.
REQ-004 Port reset_n, input, 1: reset; synchronous to clk and active-low.
REQ-005 Port clk7_en, input, 1: 7 MHz clock enable; qualifies start.
REQ-006 Port start, input, 1: request one mix pass; acted on only when clk7_en=1.
REQ-007 Port sample, input, NCH*8: signed 8-bit samples; channel i occupies [8i+7:8i].
REQ-008 Port vol, input, NCH*7: unsigned 7-bit volumes; channel i occupies [7i+6:7i].
REQ-009 Port route, input, NCH: per-channel destination; 1 = left, 0 = right.
REQ-010 Port ldatasum, output, OW: signed left mix, registered.
REQ-011 Port rdatasum, output, OW: signed right mix, registered.
REQ-012 Port valid, output, 1: one-clk pulse marking the cycle in which new sums appear on ldatasum and rdatasum.
REQ-013 Port busy, output, 1: high while a pass is in progress.
REQ-014 Port overrun, output, 1: one-clk pulse when a start request is dropped.

Function
REQ-015 States: IDLE, MAC, OUT; reset state is IDLE.
REQ-016 Accept condition: in IDLE, start=1 with clk7_en=1.
- On accept, sample, vol and route are snapshotted into internal registers.
- Both accumulators are cleared, the channel index is set to 0, and the state moves to MAC.
REQ-017 Inputs may change at any time after accept without affecting the pass in progress.
REQ-018 MAC processes one channel per clk cycle, in index order 0..NCH-1.
- The channel's product is added to the left accumulator if route[i]=1, else to the right accumulator.
- The state moves to OUT after channel NCH-1.
REQ-019 Effective volume: 64 when vol[6]=1, otherwise vol[5:0] (range 0..64).
REQ-020 Product: signed sample times unsigned effective volume, held as a 14-bit signed value (range -8192..8128), with no rounding.
REQ-021 Accumulator width: 14+clog2(NCH)+1 bits signed, so no internal overflow is possible.
REQ-022 In OUT:
- Both accumulators are converted to OW bits (see REQ-029/REQ-030) and registered onto ldatasum and rdatasum.
- valid=1 for that single cycle.
- The state then returns to IDLE.
REQ-023 Latency: valid is asserted exactly NCH+1 clk cycles after the accept cycle; ldatasum/rdatasum are stable from that cycle until the next valid.
REQ-024 busy=1 in MAC and OUT, and 0 in IDLE.
REQ-025 A start with clk7_en=1 while in MAC or OUT is dropped, and overrun pulses for 1 cycle; outputs are unaffected.
REQ-026 A start in the OUT cycle is dropped, not queued; back-to-back passes need a start in IDLE.
REQ-027 A channel with no channels routed to one side yields 0 on that side.

Reset
REQ-028 While reset_n=0 on a clk edge, the block is reset, including mid-pass: any partial pass is abandoned without asserting valid.
- State returns to IDLE.
- ldatasum=0, rdatasum=0, valid=0, busy=0, overrun=0.
- Accumulators, channel index and snapshot registers are cleared.

Configuration
REQ-029 Macro PAULA_MIXER_SAT_EN defined: each sum outside the OW signed range is clamped to +(2^(OW-1)-1) or -(2^(OW-1)).
REQ-030 Macro PAULA_MIXER_SAT_EN undefined: each sum is truncated to its low OW bits (two's-complement wrap).

Verification
REQ-031 Defaults, samples {0x7F,0x7F,0x7F,0x7F}, vol 0x40 all, route 4'b0110, start -> valid 5 clks later, ldatasum=16256, rdatasum=16256.
REQ-032 Defaults, samples {0x80 x4}, vol 0x7F (bit6 forces 64), route 4'b1111:
- with PAULA_MIXER_SAT_EN -> ldatasum=-16384, rdatasum=0;
- without it -> ldatasum=0 (wrap of -32768).
REQ-033 Sample ch0=0x10, vol0=0x20, route bit0=0; change sample0 to 0x7F one clk after accept -> rdatasum=512.
REQ-034 Second start with clk7_en=1 two clks after accept -> overrun pulses once, and valid occurs only once, at the original latency.
REQ-035 reset_n=0 during MAC cycle 2 -> next cycle busy=0, sums=0, and no valid pulse.
REQ-036 NCH=8, OW=18, all samples 0x7F, vol 64, route 8'hFF -> ldatasum=65024, rdatasum=0, valid 9 clks after accept.
